// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus-master driver: register map, FSM states, baud divisors.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spart_pkg;

  // SPART processor-side register map
  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // Baud divisors for a 100 MHz clock
  localparam logic [15:0] DIV0_DEF = 16'd1301;  // 4800
  localparam logic [15:0] DIV1_DEF = 16'd650;   // 9600
  localparam logic [15:0] DIV2_DEF = 16'd325;   // 19200
  localparam logic [15:0] DIV3_DEF = 16'd162;   // 38400

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RD,
    WR,
    GAP
  } state_t;

  // Select one 16-bit divisor out of {DIV3, DIV2, DIV1, DIV0}
  function automatic logic [15:0] div_pick(input logic [1:0] sel, input logic [63:0] divs);
    return divs[{sel, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/spart_txfifo.sv
// Synchronous byte FIFO holding transmit bytes until the SPART can take them.
// Latency: a pushed byte is visible at o_head the cycle after the push edge.
// Backpressure: o_full blocks pushes (a push while full is dropped); pop on empty is ignored.
module spart_txfifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_dat,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_cnt == CNT_FULL);
  assign o_empty   = (r_cnt == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rptr];

  // Pointers wrap naturally; the count tracks occupancy including the full state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset; occupancy is governed by the pointers
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_dat;
  end

endmodule

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor, then alternates RX drains and TX feeds.
// Latency: access one cycle after rda/tbr is seen in IDLE; rx_valid one cycle after RD; >=3 cycles between accesses.
// Backpressure: no RD while rx_valid is held; tx_ready low when the TX FIFO is full or in reset.
module spart_driver
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV0     = DIV0_DEF,
  parameter logic [15:0] DIV1     = DIV1_DEF,
  parameter logic [15:0] DIV2     = DIV2_DEF,
  parameter logic [15:0] DIV3     = DIV3_DEF,
  parameter int          TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       cfg_done,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cfg_q;
  logic        r_cfg_done;
  logic        r_last_rd;
  logic        r_rx_valid;
  logic [7:0]  r_rx_data;

  logic        w_rx_elig;
  logic        w_tx_elig;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_head;
  logic        w_drive;
  logic [7:0]  w_wdat;
  logic [15:0] w_div_new;
  logic [15:0] w_div_cur;

  // CFG_LO uses the live selection (it is being latched that cycle); CFG_HI uses the latched one
  assign w_div_new = div_pick(br_cfg,  {DIV3, DIV2, DIV1, DIV0});
  assign w_div_cur = div_pick(r_cfg_q, {DIV3, DIV2, DIV1, DIV0});

  assign w_rx_elig = rda && !r_rx_valid;
  assign w_tx_elig = tbr && !w_empty;
  assign w_push    = tx_valid && tx_ready;
  assign w_pop     = (r_state == WR) && !rst;

  assign tx_ready  = !w_full && !rst;
  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_data;
  assign cfg_done  = r_cfg_done;
  assign databus   = w_drive ? w_wdat : 8'hzz;

  spart_txfifo #(
    .DEPTH (TX_DEPTH)
  ) u_txfifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (tx_data),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= CFG_LO;
    else     r_state <= w_next;
  end

  // Next state: reconfig beats traffic; RX/TX ties broken by the round-robin bit
  always_comb begin
    w_next = r_state;
    case (r_state)
      CFG_LO: w_next = CFG_HI;
      CFG_HI: w_next = GAP;
      IDLE: begin
        if (br_cfg != r_cfg_q)         w_next = CFG_LO;
        else if (w_rx_elig && w_tx_elig) w_next = r_last_rd ? WR : RD;
        else if (w_rx_elig)            w_next = RD;
        else if (w_tx_elig)            w_next = WR;
        else                           w_next = IDLE;
      end
      RD:      w_next = GAP;
      WR:      w_next = GAP;
      GAP:     w_next = IDLE;
      default: w_next = CFG_LO;
    endcase
  end

  // Bus outputs; reset forces the bus quiet even though the state register already sits in CFG_LO
  always_comb begin
    iocs    = 1'b0;
    iorw    = 1'b1;
    ioaddr  = ADDR_DATA;
    w_drive = 1'b0;
    w_wdat  = 8'h00;
    if (!rst) begin
      case (r_state)
        CFG_LO: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = ADDR_DBL;
          w_drive = 1'b1;
          w_wdat  = w_div_new[7:0];
        end
        CFG_HI: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = ADDR_DBH;
          w_drive = 1'b1;
          w_wdat  = w_div_cur[15:8];
        end
        RD: begin
          iocs    = 1'b1;
          iorw    = 1'b1;
          ioaddr  = ADDR_DATA;
        end
        WR: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = ADDR_DATA;
          w_drive = 1'b1;
          w_wdat  = w_head;
        end
        default: ;
      endcase
    end
  end

  // Applied configuration and its done flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_q    <= 2'b00;
      r_cfg_done <= 1'b0;
    end else begin
      if (r_state == CFG_LO) r_cfg_q <= br_cfg;
      if (r_state == CFG_HI)
        r_cfg_done <= 1'b1;
      else if (r_state == IDLE && w_next == CFG_LO)
        r_cfg_done <= 1'b0;
    end
  end

  // RX holding register: filled at the end of RD, emptied by the consumer handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
    end else if (r_state == RD) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= databus;
    end else if (rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  // Round-robin bit remembers whether the last data access was a read
  always_ff @(posedge clk) begin
    if (rst)                 r_last_rd <= 1'b0;
    else if (r_state == RD)  r_last_rd <= 1'b1;
    else if (r_state == WR)  r_last_rd <= 1'b0;
  end

endmodule

// File: doc/spart_driver.md
# spart_driver

Bus-master controller that sequences the SPART's processor-side register interface. After reset it programs the baud divisor chosen by `br_cfg`. It then arbitrates between draining received bytes (SPART `rda`) and feeding queued transmit bytes (SPART `tbr`). It sits between the board-level user logic (switches, echo or command logic) and the SPART, and is the only driver of `iocs`/`iorw`/`ioaddr`/`databus`.

## Interface
- `DIV0`, default 16'd1301: divisor for `br_cfg`=00 (4800 baud at 100 MHz).
- `DIV1`, default 16'd650: divisor for `br_cfg`=01 (9600 baud).
- `DIV2`, default 16'd325: divisor for `br_cfg`=10 (19200 baud).
- `DIV3`, default 16'd162: divisor for `br_cfg`=11 (38400 baud).
- `TX_DEPTH`, default 4: TX FIFO entries; must be a power of 2, ≥2.

Ports:
- `clk` in 1: single clock; everything is posedge.
- `rst` in 1: synchronous, active-high reset.
- `br_cfg` in 2: baud select; treated as quasi-static and registered once.
- `tx_valid` in 1: user offers `tx_data`.
- `tx_data` in 8: byte to transmit.
- `tx_ready` out 1: FIFO not full; a push happens when `tx_valid`&&`tx_ready`.
- `rx_valid` out 1: `rx_data` holds an unconsumed received byte.
- `rx_data` out 8: received byte.
- `rx_ready` in 1: user consumes `rx_data` when `rx_valid`&&`rx_ready`.
- `cfg_done` out 1: divisor for the current `br_cfg` has been written.
- `iocs` out 1: SPART chip select.
- `iorw` out 1: 1 = read, 0 = write.
- `ioaddr` out 2: 00 data, 01 status (unused), 10 divisor low, 11 divisor high.
- `databus` inout 8: driven only in write cycles, high-Z otherwise.
- `rda` in 1: SPART receive data available.
- `tbr` in 1: SPART transmit buffer ready.

## Operation
- States: CFG_LO, CFG_HI, IDLE, RD, WR, GAP. Reset state is CFG_LO.
- **CFG_LO**: one cycle; `iocs`=1, `iorw`=0, `ioaddr`=10, `databus`=DIVn[7:0]. Latches the applied config register `cfg_q`=`br_cfg`. Next state is CFG_HI.
- **CFG_HI**: one cycle; `ioaddr`=11, `databus`=DIVn[15:8], with n taken from `cfg_q`. Next state is GAP. Sets `cfg_done`=1.
- **IDLE**: `iocs`=0. Decisions are evaluated in this priority order:
  - If `br_cfg`≠`cfg_q`: clear `cfg_done` and go to CFG_LO.
  - If both an RX and a TX access are eligible: choose by a 1-bit round-robin pointer `last_rd`. Choose TX if `last_rd`=1, else RX.
  - If only RX is eligible: go to RD. RX is eligible when `rda`=1 and `rx_valid`=0.
  - If only TX is eligible: go to WR. TX is eligible when `tbr`=1 and the FIFO is not empty.
  - Otherwise stay in IDLE.
- **RD**: one cycle; `iocs`=1, `iorw`=1, `ioaddr`=00. At the clock edge ending RD: `rx_data`←`databus`, `rx_valid`←1, `last_rd`←1. Next state is GAP.
- **WR**: one cycle; `iocs`=1, `iorw`=0, `ioaddr`=00, `databus`=FIFO head. At the edge the FIFO is popped and `last_rd`←0. Next state is GAP.
- **GAP**: one idle cycle with `iocs`=0, so the SPART's `rda`/`tbr` update before the next decision. Next state is IDLE.
- Bus lines outside active cycles: `iorw`=1 and `ioaddr`=00. `databus` is high-Z in every state except CFG_LO, CFG_HI and WR.
- RX backpressure: while `rx_valid`=1, no RD is issued. Overrun inside the SPART is not this block's concern.
- `rx_valid` clears on the edge where `rx_ready`=1. A new RD cannot land in that same cycle, because GAP and IDLE sit in between.
- TX FIFO:
  - Push and pop in the same cycle are legal; the count is unchanged.
  - A push when full is ignored, and `tx_ready`=0 when full.
  - Pointers are log2(TX_DEPTH) bits and wrap naturally. The count is log2(TX_DEPTH)+1 bits.
- TX bytes are written in push order. There is no drop and no reordering.

## Timing
- Reset values: `iocs` 0, `iorw` 1, `ioaddr` 00, `databus` Z, `rx_valid` 0, `rx_data` 00, `cfg_done` 0, FIFO empty, `last_rd` 0.
  - `tx_ready` is 0 while `rst`=1.
- First bus activity:
  - CFG_LO occurs in the first cycle after `rst` deasserts.
  - CFG_HI occurs in the second cycle.
  - `cfg_done`=1 from the third cycle.
- Access spacing: minimum 3 cycles between `iocs` pulses (RD/WR, GAP, IDLE).
- `rda` or `tbr` sampled in IDLE → the access happens in the next cycle.
- Read latency: `rx_valid` rises the cycle after RD.
- A `br_cfg` change takes effect only from IDLE. An access in flight completes first.
- FIFO entries survive a reconfiguration; only `rst` flushes them.
- `rst` mid-access: `iocs` deasserts on the next edge. Any partially captured RX byte is discarded.

## Structure
- Package `spart_pkg` holds:
  - SPART address constants: ADDR_DATA=00, ADDR_STAT=01, ADDR_DBL=10, ADDR_DBH=11.
  - The state enum typedef.
  - The default divisor constants.
- Sub-module `spart_txfifo`: a parameterised synchronous FIFO with push/pop/full/empty/head. The FSM, RX holding register and bus drive live in `spart_driver`.

## Test plan
- **Reset/config:** `br_cfg`=01, release `rst` → writes of 8'h8A at 10, then 8'h02 at 11, on consecutive cycles. `cfg_done` rises in cycle 3.
- **RX:**
  - Bench SPART model asserts `rda` and drives 8'h5A on a read of 00 → one RD cycle, then `rx_data`=5A and `rx_valid`=1.
  - Hold `rx_ready`=0 with `rda` still high → no further `iocs`.
- **TX burst:**
  - Push A1, A2, A3, A4, A5 with `tbr`=1 → `tx_ready` drops after 4 pushes, so A5 waits.
  - Writes to 00 carry A1..A4 in order, spaced 3 cycles apart.
- **Arbitration:** `rda`=1, `tbr`=1, FIFO holds 2 bytes, `rx_ready`=1 → accesses alternate RD, WR, RD, WR.
- **Reconfig:** change `br_cfg` 01→11 during a WR → WR and GAP complete, then writes of A2 and 00 at 10/11. The FIFO contents are retained.
- **Mid-op reset:** assert `rst` during an RD → `iocs`=0 and `rx_valid`=0 next cycle. After release, the full config sequence runs again.
